// File: rtl/card_pkg.sv
// Shared card/score types, constants and the rank-to-value mapping for the
// baccarat dealing datapath.
package card_pkg;

  typedef logic [3:0] card_t;
  typedef logic [3:0] score_t;

  localparam card_t       CARD_EMPTY = 4'd0;
  localparam int unsigned RANK_MAX   = 13;
  localparam int unsigned SCORE_MOD  = 10;

  // Ranks 1..9 count at face value; empty slots and 10/J/Q/K count as zero.
  function automatic score_t card_value(input card_t c);
    score_t v;
    v = 4'd0;
    if ((c >= 4'd1) && (c <= 4'd9)) begin
      v = score_t'(c);
    end
    return v;
  endfunction

endpackage

// File: rtl/deck_counter.sv
// Free-running deck counter: 1, 2, ..., RankMax, 1, ... Never holds zero.
module deck_counter
  import card_pkg::*;
#(
  parameter int unsigned RankMax = RANK_MAX
) (
  input  logic       clk_i,
  input  logic       rst_i,
  output logic [3:0] count_o
);

  card_t count_q, count_d;

  // Next count with wrap back to 1.
  always_comb begin
    count_d = count_q + 4'd1;
    if (count_q == 4'(RankMax)) begin
      count_d = 4'd1;
    end
  end

  // Count register; synchronous reset to the first rank.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= 4'd1;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/hand_datapath.sv
// Datapath half of the baccarat dealing handshake: captures cards into the
// strobed slot, flags illegal strobe patterns and reports hand scores.
// Optional: HAND_DATAPATH_EXT_DECK_EN replaces the internal deck counter with
// an external ext_card input.
module hand_datapath
  import card_pkg::*;
(
  input  logic       slow_clock,
  input  logic       reset,
  input  logic       load_pcard1,
  input  logic       load_pcard2,
  input  logic       load_pcard3,
  input  logic       load_dcard1,
  input  logic       load_dcard2,
  input  logic       load_dcard3,
`ifdef HAND_DATAPATH_EXT_DECK_EN
  input  logic [3:0] ext_card,
`endif
  output logic [3:0] pcard1,
  output logic [3:0] pcard2,
  output logic [3:0] pcard3,
  output logic [3:0] dcard1,
  output logic [3:0] dcard2,
  output logic [3:0] dcard3,
  output logic [3:0] pscore,
  output logic [3:0] dscore,
  output logic [2:0] deal_count,
  output logic       protocol_err
);

  // Slot order: [0..2] player 1..3, [3..5] dealer 1..3.
  logic [5:0] load;
  card_t      card_q [6];
  card_t      card_d [6];
  logic [2:0] count_q, count_d;
  logic       err_q, err_d;
  card_t      card_src;
  logic       src_ok;
  logic       one_hot;
  logic       slot_ok;
  logic [5:0] prev_ok;
  logic [4:0] psum, dsum;

  assign load = {load_dcard3, load_dcard2, load_dcard1, load_pcard3, load_pcard2, load_pcard1};

`ifdef HAND_DATAPATH_EXT_DECK_EN
  assign card_src = ext_card;
  assign src_ok   = (ext_card != CARD_EMPTY) && (ext_card <= 4'(RANK_MAX));
`else
  deck_counter #(
    .RankMax(RANK_MAX)
  ) u_deck_counter (
    .clk_i  (slow_clock),
    .rst_i  (reset),
    .count_o(card_src)
  );
  assign src_ok = 1'b1;
`endif

  // Slot 1 of each side has no predecessor; slots 2/3 need the previous slot filled.
  assign prev_ok = {card_q[4] != CARD_EMPTY, card_q[3] != CARD_EMPTY, 1'b1,
                    card_q[1] != CARD_EMPTY, card_q[0] != CARD_EMPTY, 1'b1};

  assign one_hot = (load != 6'd0) && ((load & (load - 6'd1)) == 6'd0);

  // Legality check and capture/next-state for cards, count and sticky error.
  always_comb begin
    card_d  = card_q;
    count_d = count_q;
    err_d   = err_q;
    slot_ok = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (load[i]) begin
        slot_ok = (card_q[i] == CARD_EMPTY) && prev_ok[i];
      end
    end
    if (one_hot && slot_ok && src_ok) begin
      for (int i = 0; i < 6; i++) begin
        if (load[i]) begin
          card_d[i] = card_src;
        end
      end
      count_d = count_q + 3'd1;
    end else if (load != 6'd0) begin
      err_d = 1'b1;
    end
  end

  // Hand state registers; reset discards the whole hand and clears the error.
  always_ff @(posedge slow_clock) begin
    if (reset) begin
      for (int i = 0; i < 6; i++) begin
        card_q[i] <= CARD_EMPTY;
      end
      count_q <= 3'd0;
      err_q   <= 1'b0;
    end else begin
      card_q  <= card_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  // Hand scores from the registered cards; 5-bit sum covers the 27 maximum.
  always_comb begin
    psum   = 5'(card_value(card_q[0])) + 5'(card_value(card_q[1])) + 5'(card_value(card_q[2]));
    dsum   = 5'(card_value(card_q[3])) + 5'(card_value(card_q[4])) + 5'(card_value(card_q[5]));
    pscore = 4'(psum % 5'(SCORE_MOD));
    dscore = 4'(dsum % 5'(SCORE_MOD));
  end

  assign pcard1       = card_q[0];
  assign pcard2       = card_q[1];
  assign pcard3       = card_q[2];
  assign dcard1       = card_q[3];
  assign dcard2       = card_q[4];
  assign dcard3       = card_q[5];
  assign deal_count   = count_q;
  assign protocol_err = err_q;

endmodule

// File: tb/tb_hand_datapath.sv
// Directed bench for hand_datapath: expectations are queued as each step is
// driven and drained against the outputs one time unit after the clock edge.
module tb_hand_datapath;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       p1 = 1'b0, p2 = 1'b0, p3 = 1'b0, d1 = 1'b0, d2 = 1'b0, d3 = 1'b0;
  logic [3:0] pcard1, pcard2, pcard3, dcard1, dcard2, dcard3;
  logic [3:0] pscore, dscore;
  logic [2:0] deal_count;
  logic       protocol_err;
`ifdef HAND_DATAPATH_EXT_DECK_EN
  logic [3:0] ext_card = 4'd1;
`endif

  int checks = 0;
  int errors = 0;

  localparam int SelP1 = 0, SelP2 = 1, SelP3 = 2, SelD1 = 3, SelD2 = 4, SelD3 = 5;
  localparam int SelPs = 6, SelDs = 7, SelCnt = 8, SelErr = 9;

  // Slot strobe vectors: bit0 p1, bit1 p2, bit2 p3, bit3 d1, bit4 d2, bit5 d3.
  localparam logic [5:0] LP1 = 6'b000001, LP2 = 6'b000010, LP3 = 6'b000100;
  localparam logic [5:0] LD1 = 6'b001000, LD2 = 6'b010000, LD3 = 6'b100000;

  typedef struct {
    string      tag;
    int         sel;
    logic [3:0] val;
  } exp_t;

  exp_t sb[$];

  hand_datapath dut (
    .slow_clock  (clk),
    .reset       (reset),
    .load_pcard1 (p1),
    .load_pcard2 (p2),
    .load_pcard3 (p3),
    .load_dcard1 (d1),
    .load_dcard2 (d2),
    .load_dcard3 (d3),
`ifdef HAND_DATAPATH_EXT_DECK_EN
    .ext_card    (ext_card),
`endif
    .pcard1      (pcard1),
    .pcard2      (pcard2),
    .pcard3      (pcard3),
    .dcard1      (dcard1),
    .dcard2      (dcard2),
    .dcard3      (dcard3),
    .pscore      (pscore),
    .dscore      (dscore),
    .deal_count  (deal_count),
    .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] observe(input int sel);
    logic [3:0] v;
    case (sel)
      SelP1:   v = pcard1;
      SelP2:   v = pcard2;
      SelP3:   v = pcard3;
      SelD1:   v = dcard1;
      SelD2:   v = dcard2;
      SelD3:   v = dcard3;
      SelPs:   v = pscore;
      SelDs:   v = dscore;
      SelCnt:  v = {1'b0, deal_count};
      default: v = {3'b000, protocol_err};
    endcase
    return v;
  endfunction

  task automatic expect_v(input string tag, input int sel, input logic [3:0] val);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.val = val;
    sb.push_back(e);
  endtask

  // Queue an empty hand with the given error flag.
  task automatic expect_empty(input string tag, input logic err);
    for (int s = SelP1; s <= SelCnt; s++) expect_v(tag, s, 4'd0);
    expect_v(tag, SelErr, {3'b000, err});
  endtask

  task automatic drain();
    exp_t       e;
    logic [3:0] o;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = observe(e.sel);
      checks++;
      assert (o === e.val) else begin
        errors++;
        $error("FAIL %s sel=%0d observed=%0d expected=%0d", e.tag, e.sel, o, e.val);
      end
    end
  endtask

  // One clock with the given strobes applied, then outputs are settled.
  task automatic step(input logic [5:0] v);
    {d3, d2, d1, p3, p2, p1} = v;
    @(posedge clk);
    #1;
    {d3, d2, d1, p3, p2, p1} = 6'd0;
  endtask

  task automatic idle(input int n);
    repeat (n) step(6'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(6'd0);
    reset = 1'b0;
  endtask

  initial begin
    // Reset state.
    do_reset();
    expect_empty("reset", 1'b0);
    drain();

    // Basic hand, extended to all six slots.
    step(LP1);
    expect_v("basic_p1", SelP1, 4'd1);
    drain();
    step(LD1);
    step(LP2);
    step(LD2);
    expect_v("basic_p1", SelP1, 4'd1);
    expect_v("basic_d1", SelD1, 4'd2);
    expect_v("basic_p2", SelP2, 4'd3);
    expect_v("basic_d2", SelD2, 4'd4);
    expect_v("basic_ps", SelPs, 4'd4);
    expect_v("basic_ds", SelDs, 4'd6);
    expect_v("basic_cnt", SelCnt, 4'd4);
    expect_v("basic_err", SelErr, 4'd0);
    drain();
    step(LP3);
    step(LD3);
    expect_v("six_p3", SelP3, 4'd5);
    expect_v("six_d3", SelD3, 4'd6);
    expect_v("six_ps", SelPs, 4'd9);
    expect_v("six_ds", SelDs, 4'd2);
    expect_v("six_cnt", SelCnt, 4'd6);
    expect_v("six_err", SelErr, 4'd0);
    drain();

    // Face card and deck wrap.
    do_reset();
    idle(12);
    step(LP1);
    expect_v("face_p1", SelP1, 4'd13);
    expect_v("face_ps", SelPs, 4'd0);
    drain();
    step(LD1);
    expect_v("wrap_d1", SelD1, 4'd1);
    expect_v("wrap_ds", SelDs, 4'd1);
    expect_v("wrap_cnt", SelCnt, 4'd2);
    drain();

    // Score modulo.
    do_reset();
    idle(6);
    step(LP1);
    step(LP2);
    step(LP3);
    expect_v("mod_p1", SelP1, 4'd7);
    expect_v("mod_p2", SelP2, 4'd8);
    expect_v("mod_p3", SelP3, 4'd9);
    expect_v("mod_ps", SelPs, 4'd4);
    expect_v("mod_cnt", SelCnt, 4'd3);
    drain();

    // Simultaneous strobes, then a legal deal with the error still sticky.
    do_reset();
    step(LP1 | LD1);
    expect_empty("simul", 1'b1);
    drain();
    step(LP1);
    expect_v("after_simul_p1", SelP1, 4'd2);
    expect_v("after_simul_cnt", SelCnt, 4'd1);
    expect_v("after_simul_err", SelErr, 4'd1);
    drain();

    // Out-of-order third card.
    do_reset();
    step(LP3);
    expect_empty("order_p3", 1'b1);
    drain();

    // Out-of-order dealer slot 2.
    do_reset();
    step(LD2);
    expect_empty("order_d2", 1'b1);
    drain();

    // Overwrite via a held strobe: second cycle is an illegal re-deal.
    do_reset();
    step(LP1);
    expect_v("held_first_err", SelErr, 4'd0);
    drain();
    step(LP1);
    expect_v("overwrite_p1", SelP1, 4'd1);
    expect_v("overwrite_cnt", SelCnt, 4'd1);
    expect_v("overwrite_err", SelErr, 4'd1);
    drain();

    // Reset mid-hand clears cards, count, scores and the sticky error.
    do_reset();
    step(LP1);
    step(LD1);
    step(LP2);
    step(LP1 | LP3);
    expect_v("mid_pre_err", SelErr, 4'd1);
    expect_v("mid_pre_cnt", SelCnt, 4'd3);
    drain();
    do_reset();
    expect_empty("mid_reset", 1'b0);
    drain();
    step(LD1);
    expect_v("post_reset_d1", SelD1, 4'd1);
    expect_v("post_reset_cnt", SelCnt, 4'd1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hand_datapath.md
Name: hand_datapath

Overview:
Datapath side of the baccarat dealing handshake. Receives the per-slot load strobes from the dealing state machine and deals a card into the strobed slot from an internal free-running deck counter. Holds the six card registers and returns pscore, dscore and pcard3 to the state machine. Also returns the card values to the HEX display logic.

Parameters:
RANK_MAX, 13, highest card rank; the deck counter wraps RANK_MAX -> 1.
SCORE_MOD, 10, modulus for hand scores.

Ports:
slow_clock  input  1  sole clock; all state updates on rising edge.
reset  input  1  synchronous, active-high reset.
load_pcard1  input  1  deal into player slot 1.
load_pcard2  input  1  deal into player slot 2.
load_pcard3  input  1  deal into player slot 3.
load_dcard1  input  1  deal into dealer slot 1.
load_dcard2  input  1  deal into dealer slot 2.
load_dcard3  input  1  deal into dealer slot 3.
pcard1, pcard2, pcard3  output  4 each  player card ranks; 0 = slot empty.
dcard1, dcard2, dcard3  output  4 each  dealer card ranks; 0 = slot empty.
pscore  output  4  player hand score, 0..9.
dscore  output  4  dealer hand score, 0..9.
deal_count  output  3  number of cards dealt this hand, 0..6.
protocol_err  output  1  sticky flag for an illegal strobe pattern.

Behaviour:
- Reset (sampled high at a rising edge):
  - all six card registers <= 0.
  - deal_count <= 0.
  - protocol_err <= 0.
  - deck counter <= 1.
  - Reset takes priority over any load. Reset in the middle of a hand discards the whole hand.
- Deck counter:
  - Advances every cycle that reset is low: 1, 2, ..., RANK_MAX, 1, ...
  - Never holds 0.
- Dealt card: the value the deck counter holds in the cycle the strobe is sampled (the pre-advance value).
- Latency: a strobe asserted in cycle N makes the card register show the new value after edge N. There is no acknowledge; a strobe is consumed in one cycle.
- A strobe held high for several cycles counts as a new deal request in each of those cycles. The rules below apply to every one of them.
- Legal deal, all four conditions met:
  - exactly one strobe is high;
  - the target slot is empty (0);
  - for slot 2, slot 1 of the same side is already filled;
  - for slot 3, slot 2 of the same side is already filled.
  On a legal deal the slot is captured and deal_count increments.
- Illegal cycle:
  - Causes: two or more strobes high, a strobe to an already-filled slot, or an out-of-order slot.
  - No card register changes and deal_count holds.
  - protocol_err <= 1 and stays set until reset.
- No strobes: card registers and deal_count hold; the counter still advances.
- Card value: rank 1..9 -> value = rank; rank 0 (empty) and ranks 10..13 -> value 0.
- Scores:
  - Combinational from the registered cards: pscore = (v(pcard1)+v(pcard2)+v(pcard3)) mod SCORE_MOD, same form for dscore.
  - The intermediate sum is 5 bits wide (maximum 27).
- pcard3 doubles as the third-card input the state machine uses for its third-card decision; 0 means no third card was dealt.

Optional Feature:
- Macro: HAND_DATAPATH_EXT_DECK_EN.
- Defined:
  - adds input ext_card [3:0]; each legal deal captures ext_card instead of the deck counter.
  - ext_card of 0 or greater than RANK_MAX makes the deal illegal: no capture, protocol_err set.
  - the internal counter is not instantiated.
- Undefined: no ext_card port; the internal deck counter is the card source.

Decomposition:
- Package card_pkg holds:
  - typedef card_t (logic [3:0]);
  - typedef score_t (logic [3:0]);
  - constants CARD_EMPTY = 0, RANK_MAX = 13, SCORE_MOD = 10;
  - function card_value(card_t) returning score_t.
- One natural sub-module, deck_counter: free-running 1..RANK_MAX wrap counter with synchronous reset to 1. Instantiated only when HAND_DATAPATH_EXT_DECK_EN is undefined.
- Score arithmetic stays in hand_datapath.

Test Plan:
- Basic hand: release reset, then strobe load_pcard1, load_dcard1, load_pcard2, load_dcard2 in 4 consecutive cycles -> pcard1=1, dcard1=2, pcard2=3, dcard2=4; pscore=4, dscore=6; deal_count=4; protocol_err=0.
- Face card and wrap: release reset, idle 12 cycles, then load_pcard1 -> pcard1=13 and pscore=0. On the next cycle load_dcard1 -> dcard1=1.
- Score modulo: release reset, idle 6 cycles, then strobe load_pcard1, load_pcard2, load_pcard3 in 3 consecutive cycles -> cards 7, 8, 9; pscore=(7+8+9) mod 10=4; pcard3=9.
- Simultaneous strobes: load_pcard1 and load_dcard1 high in the same cycle -> all cards stay 0, deal_count=0, protocol_err=1. A later legal load_pcard1 still captures, and protocol_err stays 1.
- Order and overwrite: load_pcard3 with pcard2 empty -> no capture, protocol_err=1. After a reset, a second load_pcard1 on a filled slot 1 -> pcard1 unchanged, protocol_err=1.
- Reset mid-hand: deal 3 cards, then assert reset for one cycle -> all cards 0, scores 0, deal_count=0, protocol_err=0. The first deal after reset returns card 1.
